booth_multiplier: RTL and testbench

BOOTH_MULTIPLIER -- requirements
Module: booth_multiplier

---
 rtl/booth_multiplier_pkg.sv | 14 +
 rtl/booth_multiplier_dff.sv | 28 ++
 rtl/booth_multiplier.sv | 107 ++++++++++
 tb/tb_booth_multiplier.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/booth_multiplier_pkg.sv
// Shared definitions for the radix-2 Booth multiplier.
//   DEFAULT_WIDTH : default operand width in bits
//   state_t       : control FSM encoding (IDLE / WORK / DONE)
package booth_multiplier_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WORK = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/booth_multiplier_dff.sv
// Generic parameterized register with asynchronous active-high reset to zero
// and a synchronous load enable.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, clears q
//   en  : load enable; q holds when low
//   d   : next value
//   q   : registered value
module booth_multiplier_dff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/booth_multiplier.sv
// Sequential signed radix-2 Booth multiplier: one Booth step per clock,
// WIDTH steps per operation, result registered on entry to DONE.
//   clk          : rising-edge clock
//   rst          : asynchronous active-high reset
//   start        : request, sampled in IDLE; must drop in DONE before re-arm
//   multiplicand : signed operand M, captured on the start edge
//   multiplier   : signed operand Q, captured on the start edge
//   product      : registered signed M*Q, held until the next DONE entry
//   busy         : high while in WORK
//   done         : high while in DONE
module booth_multiplier
    import booth_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [1:0]         state_q;
    state_t             state_d;
    logic [WIDTH:0]     a_q, a_d;
    logic [WIDTH:0]     m_q, m_d;
    logic [WIDTH-1:0]   qr_q, qr_d;
    logic               q1_q, q1_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] product_d;
    logic               product_en;
    logic               busy_d, done_d;
    logic [WIDTH:0]     sum;

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_t'(state_q);
        a_d        = a_q;
        m_d        = m_q;
        qr_d       = qr_q;
        q1_d       = q1_q;
        count_d    = count_q;
        product_en = 1'b0;
        product_d  = {a_q[WIDTH-1:0], qr_q};

        // Booth recoding of the current multiplier bit pair, WIDTH+1 bits wide
        // so that M = -2^(WIDTH-1) cannot overflow when negated.
        case ({qr_q[0], q1_q})
            2'b01:   sum = a_q + m_q;
            2'b10:   sum = a_q - m_q;
            default: sum = a_q;
        endcase

        case (state_t'(state_q))
            IDLE: begin
                if (start) begin
                    state_d = WORK;
                    a_d     = '0;
                    m_d     = {multiplicand[WIDTH-1], multiplicand};
                    qr_d    = multiplier;
                    q1_d    = 1'b0;
                    count_d = '0;
                end
            end
            WORK: begin
                if (count_q == CW'(WIDTH)) begin
                    state_d    = DONE;
                    product_en = 1'b1;
                end else begin
                    // Arithmetic right shift of {sum, qr, q1}.
                    a_d     = {sum[WIDTH], sum[WIDTH:1]};
                    qr_d    = {sum[0], qr_q[WIDTH-1:1]};
                    q1_d    = qr_q[0];
                    count_d = count_q + 1'b1;
                end
            end
            DONE: begin
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flags are registered from the next state so they track the state
        // register exactly.
        busy_d = (state_d == WORK);
        done_d = (state_d == DONE);
    end

    booth_multiplier_dff #(.W(2))       u_state   (.clk(clk), .rst(rst), .en(1'b1),       .d(state_d),   .q(state_q));
    booth_multiplier_dff #(.W(WIDTH+1)) u_a       (.clk(clk), .rst(rst), .en(1'b1),       .d(a_d),       .q(a_q));
    booth_multiplier_dff #(.W(WIDTH+1)) u_m       (.clk(clk), .rst(rst), .en(1'b1),       .d(m_d),       .q(m_q));
    booth_multiplier_dff #(.W(WIDTH))   u_qr      (.clk(clk), .rst(rst), .en(1'b1),       .d(qr_d),      .q(qr_q));
    booth_multiplier_dff #(.W(1))       u_q1      (.clk(clk), .rst(rst), .en(1'b1),       .d(q1_d),      .q(q1_q));
    booth_multiplier_dff #(.W(CW))      u_count   (.clk(clk), .rst(rst), .en(1'b1),       .d(count_d),   .q(count_q));
    booth_multiplier_dff #(.W(2*WIDTH)) u_product (.clk(clk), .rst(rst), .en(product_en), .d(product_d), .q(product));
    booth_multiplier_dff #(.W(1))       u_busy    (.clk(clk), .rst(rst), .en(1'b1),       .d(busy_d),    .q(busy));
    booth_multiplier_dff #(.W(1))       u_done    (.clk(clk), .rst(rst), .en(1'b1),       .d(done_d),    .q(done));

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier (WIDTH = 16).
module tb_booth_multiplier;

    localparam int WIDTH   = 16;
    localparam int LATENCY = 17;
    localparam int BOUND   = 40;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [WIDTH-1:0]   multiplicand = '0;
    logic [WIDTH-1:0]   multiplier = '0;
    logic [2*WIDTH-1:0] product;
    logic               busy;
    logic               done;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [2*WIDTH-1:0] exp_q[$];
    logic [2*WIDTH-1:0] last_product = '0;

    booth_multiplier #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2*WIDTH-1:0] model(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] q);
        longint pm;
        pm = longint'($signed(m)) * longint'($signed(q));
        return pm[2*WIDTH-1:0];
    endfunction

    // One complete operation. exp is pushed to the scoreboard at E0 and
    // popped when done rises. disturb scrambles operands/start during WORK;
    // hold keeps start high through DONE for a few cycles.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] q,
                          input logic [2*WIDTH-1:0] exp, input bit disturb, input bit hold);
        int cycles;
        logic [2*WIDTH-1:0] e;
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        exp_q.push_back(exp);
        tick();  // E0
        start = 1'b0;
        check({tag, " busy after E0"}, 64'(busy), 64'd1);
        check({tag, " product held into WORK"}, 64'(product), 64'(last_product));
        cycles = 0;
        while (cycles < BOUND) begin
            if (disturb) begin
                multiplicand = WIDTH'($urandom);
                multiplier   = WIDTH'($urandom);
                start        = cycles[0];
            end
            if (hold) start = 1'b1;
            tick();
            cycles++;
            check({tag, " busy/done exclusive"}, 64'(busy & done), 64'd0);
            if (done) break;
        end
        check({tag, " latency"}, 64'(cycles), 64'(LATENCY));
        check({tag, " busy low in DONE"}, 64'(busy), 64'd0);
        e = exp_q.pop_front();
        check({tag, " product"}, 64'(product), 64'(e));
        last_product = e;
        if (hold) begin
            for (int i = 0; i < 3; i++) begin
                tick();
                check({tag, " done held"}, 64'(done), 64'd1);
                check({tag, " no restart"}, 64'(busy), 64'd0);
            end
        end
        start = 1'b0;
        tick();
        check({tag, " idle done"}, 64'(done), 64'd0);
        check({tag, " idle busy"}, 64'(busy), 64'd0);
        check({tag, " product held in IDLE"}, 64'(product), 64'(last_product));
    endtask

    initial begin
        logic [WIDTH-1:0] rm, rq;

        // Reset state, before any clock edge.
        #2;
        check("reset product", 64'(product), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("post-reset idle", 64'({busy, done}), 64'd0);

        run_op("3x5",        16'd3,      16'd5,      32'h0000_000F, 1'b0, 1'b0);
        run_op("-7x6",       16'hFFF9,   16'd6,      32'hFFFF_FFD6, 1'b0, 1'b0);
        run_op("minxmin",    16'h8000,   16'h8000,   32'h4000_0000, 1'b0, 1'b0);
        run_op("maxxmin",    16'h7FFF,   16'h8000,   32'hC000_8000, 1'b0, 1'b0);

        // Abort mid-WORK with an asynchronous reset between clock edges.
        multiplicand = 16'd5;
        multiplier   = 16'd9;
        start        = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("abort busy before reset", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("abort product", 64'(product), 64'd0);
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        last_product = '0;
        tick();
        rst = 1'b0;
        tick();
        check("abort idle", 64'({busy, done}), 64'd0);

        run_op("2x-1",       16'd2,      16'hFFFF,   32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("zero hold",  16'h1234,   16'd0,      32'h0000_0000, 1'b0, 1'b1);
        run_op("disturb",    16'd100,    16'hFFFD,   32'hFFFF_FED4, 1'b1, 1'b0);

        for (int k = 0; k < 4; k++) begin
            rm = WIDTH'($urandom);
            rq = WIDTH'($urandom);
            run_op("random", rm, rq, model(rm, rq), 1'b0, 1'b0);
        end

        check("scoreboard drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
